// File: rtl/booth_pkg.sv
// Shared radix-4 Booth group definitions used by the group encoder and
// the partial-product action decoder.
package booth_pkg;

  typedef logic [2:0] booth_grp_t;

  localparam booth_grp_t BOOTH_Z0  = 3'b000;
  localparam booth_grp_t BOOTH_P1A = 3'b001;
  localparam booth_grp_t BOOTH_P1B = 3'b010;
  localparam booth_grp_t BOOTH_P2  = 3'b011;
  localparam booth_grp_t BOOTH_M2  = 3'b100;
  localparam booth_grp_t BOOTH_M1A = 3'b101;
  localparam booth_grp_t BOOTH_M1B = 3'b110;
  localparam booth_grp_t BOOTH_Z1  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } booth_state_t;

  // Multiple of Y selected by a group: -2..+2.
  function automatic int booth_weight(booth_grp_t grp);
    int w;
    case (grp)
      BOOTH_P1A, BOOTH_P1B: w = 1;
      BOOTH_P2:             w = 2;
      BOOTH_M2:             w = -2;
      BOOTH_M1A, BOOTH_M1B: w = -1;
      default:              w = 0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/booth_group_encoder_if.sv
// Operand request and Booth group stream between the encoder (master)
// and its consumer (slave).
interface booth_group_encoder_if
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
);
  localparam int NGRP = WIDTH / 2;
  localparam int IW   = $clog2(NGRP);

  logic             start;
  logic [WIDTH-1:0] x;
  logic             busy;
  logic             g_valid;
  logic             g_ready;
  booth_grp_t       g;
  logic [IW-1:0]    g_idx;
  logic             g_last;
  logic             done;

  modport master (
    input  start, x, g_ready,
    output busy, g_valid, g, g_idx, g_last, done
  );

  modport slave (
    output start, x, g_ready,
    input  busy, g_valid, g, g_idx, g_last, done
  );

endinterface

// File: rtl/booth_group_encoder.sv
// Sequential radix-4 Booth recoder: captures X on start and streams one
// 3-bit group per handshake, least-significant group first.
module booth_group_encoder
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_group_encoder_if.master bus
);

  localparam int NGRP = WIDTH / 2;
  localparam int IW   = $clog2(NGRP);
  localparam logic [IW-1:0] LAST_IDX = IW'(NGRP - 1);

  booth_state_t   state_q, state_d;
  logic [WIDTH:0] sr_q, sr_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic           busy_q, busy_d;
  logic           g_valid_q, g_valid_d;
  booth_grp_t     g_q, g_d;
  logic [IW-1:0]  g_idx_q, g_idx_d;
  logic           g_last_q, g_last_d;
  logic           done_q, done_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_EMIT;
          sr_d    = {bus.x, 1'b0};
          idx_d   = '0;
        end
      end
      ST_EMIT: begin
        if (bus.g_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            // Sign-filling shift keeps the top group correct for negative X.
            sr_d  = {{2{sr_q[WIDTH]}}, sr_q[WIDTH:2]};
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next-state view so they change
    // together with the state and never see start combinationally.
    busy_d    = (state_d != ST_IDLE);
    g_valid_d = (state_d == ST_EMIT);
    done_d    = (state_d == ST_DONE);
    g_d       = g_valid_d ? booth_grp_t'(sr_d[2:0]) : BOOTH_Z0;
    g_idx_d   = g_valid_d ? idx_d : '0;
    g_last_d  = g_valid_d && (idx_d == LAST_IDX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      g_valid_q <= 1'b0;
      g_q       <= BOOTH_Z0;
      g_idx_q   <= '0;
      g_last_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      g_valid_q <= g_valid_d;
      g_q       <= g_d;
      g_idx_q   <= g_idx_d;
      g_last_q  <= g_last_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.g_valid = g_valid_q;
  assign bus.g       = g_q;
  assign bus.g_idx   = g_idx_q;
  assign bus.g_last  = g_last_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_booth_group_encoder.sv
// Scoreboard bench for booth_group_encoder: expected groups are queued when
// an operand is started and compared against the groups actually transferred.
module tb_booth_group_encoder;
  import booth_pkg::*;

  localparam int WIDTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    booth_grp_t g;
    logic [1:0] idx;
    logic       last;
    logic       rdy;
  } obs_t;

  typedef struct {
    booth_grp_t g;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  obs_t obs_q[$];
  exp_t exp_q[$];
  int   done_cyc, busy_cyc, idle_viol;

  booth_group_encoder_if #(.WIDTH(WIDTH)) bus ();

  booth_group_encoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected groups straight from the definition {x[2i+1], x[2i], x[2i-1]}.
  function automatic void push_expected(input logic [7:0] xv);
    logic [8:0] ext;
    exp_t       e;
    ext = {xv, 1'b0};
    for (int i = 0; i < 4; i++) begin
      e.g    = ext[2*i +: 3];
      e.idx  = 2'(i);
      e.last = (i == 3);
      exp_q.push_back(e);
    end
  endfunction

  // Starts one operand and records every presented group until done.
  task automatic collect(input logic [7:0] xv, input int stall, input int rdy_pct,
                         input bit pulse_start, input logic [7:0] px);
    int   nstall;
    logic rdy;
    obs_t o;
    obs_q.delete();
    done_cyc  = -1;
    busy_cyc  = 0;
    idle_viol = 0;
    nstall    = stall;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.x       = xv;
    bus.g_ready = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bus.start = (pulse_start && cyc == 2);
      bus.x     = (pulse_start && cyc == 2) ? px : 8'($urandom);
      if (bus.g_valid && nstall > 0) begin
        rdy = 1'b0;
        nstall--;
      end else begin
        rdy = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
      end
      bus.g_ready = rdy;
      if (bus.busy) busy_cyc++;
      if (bus.g_valid) begin
        o.g = bus.g; o.idx = bus.g_idx; o.last = bus.g_last; o.rdy = rdy;
        obs_q.push_back(o);
      end else if (bus.g !== 3'b000 || bus.g_idx !== 2'b00 || bus.g_last !== 1'b0) begin
        idle_viol++;
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.start   = 1'b0;
    bus.g_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.x = '0; bus.g_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.g_valid, bus.g_last, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags busy/valid/last/done=%b required 0000",
               {bus.busy, bus.g_valid, bus.g_last, bus.done});
    end
    checks++;
    if ({bus.g, bus.g_idx} !== 5'b0) begin
      errors++;
      $display("FAIL reset_group g=%b g_idx=%0d required 000/0", bus.g, bus.g_idx);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] vec [4];
    exp_t e;
    int   sum;
    vec[0] = 8'h00; vec[1] = 8'h7F; vec[2] = 8'h80; vec[3] = 8'h55;
    for (int v = 0; v < 4; v++) begin
      push_expected(vec[v]);
      collect(vec[v], 0, 100, 1'b0, 8'h00);
      sum = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
        if (!obs_q[k].rdy) continue;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL vec_extra x=%h g=%b", vec[v], obs_q[k].g);
        end else begin
          e = exp_q.pop_front();
          if ({obs_q[k].g, obs_q[k].idx, obs_q[k].last} !== {e.g, e.idx, e.last}) begin
            errors++;
            $display("FAIL vec_group x=%h got g=%b idx=%0d last=%b required g=%b idx=%0d last=%b",
                     vec[v], obs_q[k].g, obs_q[k].idx, obs_q[k].last, e.g, e.idx, e.last);
          end
        end
        sum += booth_weight(obs_q[k].g) * (1 << (2 * obs_q[k].idx));
      end
      checks++;
      if (exp_q.size() != 0 || sum != int'($signed(vec[v]))) begin
        errors++;
        $display("FAIL vec_sum x=%h sum=%0d missing=%0d required sum=%0d", vec[v], sum,
                 exp_q.size(), int'($signed(vec[v])));
      end
      exp_q.delete();
      checks++;
      if (done_cyc != 5 || busy_cyc != 5 || idle_viol != 0) begin
        errors++;
        $display("FAIL vec_timing x=%h done_cyc=%0d busy=%0d idle_viol=%0d required 5/5/0",
                 vec[v], done_cyc, busy_cyc, idle_viol);
      end
      $display("op vector x=%h sum=%0d done_cyc=%0d", vec[v], sum, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   held;
    push_expected(8'h7F);
    collect(8'h7F, 3, 100, 1'b0, 8'h00);
    held = 0;
    for (int k = 0; k < 4 && k < obs_q.size(); k++)
      if (obs_q[k].g === BOOTH_M1B && obs_q[k].idx === 2'd0) held++;
    checks++;
    if (held != 4) begin
      errors++;
      $display("FAIL bp_hold cycles_with_110_idx0=%0d required 4", held);
    end
    for (int k = 0; k < obs_q.size(); k++) begin
      if (!obs_q[k].rdy) continue;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bp_extra g=%b", obs_q[k].g);
      end else begin
        e = exp_q.pop_front();
        if ({obs_q[k].g, obs_q[k].idx, obs_q[k].last} !== {e.g, e.idx, e.last}) begin
          errors++;
          $display("FAIL bp_group got g=%b idx=%0d required g=%b idx=%0d",
                   obs_q[k].g, obs_q[k].idx, e.g, e.idx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cyc != 8 || busy_cyc != 8) begin
      errors++;
      $display("FAIL bp_timing missing=%0d done_cyc=%0d busy=%0d required 0/8/8",
               exp_q.size(), done_cyc, busy_cyc);
    end
    exp_q.delete();
    $display("op backpressure x=7f done_cyc=%0d", done_cyc);
  endtask

  task automatic test_start_ignored();
    exp_t e;
    push_expected(8'h7F);
    collect(8'h7F, 0, 100, 1'b1, 8'h80);
    for (int k = 0; k < obs_q.size(); k++) begin
      if (!obs_q[k].rdy) continue;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ign_extra g=%b", obs_q[k].g);
      end else begin
        e = exp_q.pop_front();
        if ({obs_q[k].g, obs_q[k].idx} !== {e.g, e.idx}) begin
          errors++;
          $display("FAIL ign_group got g=%b idx=%0d required g=%b idx=%0d",
                   obs_q[k].g, obs_q[k].idx, e.g, e.idx);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cyc != 5) begin
      errors++;
      $display("FAIL ign_timing missing=%0d done_cyc=%0d required 0/5", exp_q.size(), done_cyc);
    end
    exp_q.delete();
    $display("op start_ignored x=7f done_cyc=%0d", done_cyc);
  endtask

  task automatic test_reset_mid();
    bit   seen;
    exp_t e;
    seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.x = 8'h55; bus.g_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.g_valid && bus.g_idx == 2'd2) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_reach_idx2 g_idx=%0d required 2", bus.g_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.g_valid, bus.busy, bus.g} !== 5'b0) begin
      errors++;
      $display("FAIL rst_async valid=%b busy=%b g=%b required 0/0/000",
               bus.g_valid, bus.busy, bus.g);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.g_ready = 1'b0;
    @(negedge clk);
    push_expected(8'h7F);
    collect(8'h7F, 0, 100, 1'b0, 8'h00);
    for (int k = 0; k < obs_q.size(); k++) begin
      if (!obs_q[k].rdy) continue;
      checks++;
      e = exp_q.size() ? exp_q.pop_front() : '{g: 3'bxxx, idx: 2'bxx, last: 1'bx};
      if ({obs_q[k].g, obs_q[k].idx, obs_q[k].last} !== {e.g, e.idx, e.last}) begin
        errors++;
        $display("FAIL rst_restart got g=%b idx=%0d required g=%b idx=%0d",
                 obs_q[k].g, obs_q[k].idx, e.g, e.idx);
      end
    end
    checks++;
    if (exp_q.size() != 0 || done_cyc != 5) begin
      errors++;
      $display("FAIL rst_restart_timing missing=%0d done_cyc=%0d required 0/5",
               exp_q.size(), done_cyc);
    end
    exp_q.delete();
    $display("op reset_restart x=7f done_cyc=%0d", done_cyc);
  endtask

  task automatic test_random();
    logic [7:0] xv;
    exp_t       e;
    int         sum;
    for (int n = 0; n < 1000; n++) begin
      xv = 8'($urandom_range(255));
      push_expected(xv);
      collect(xv, 0, 70, 1'b0, 8'h00);
      sum = 0;
      for (int k = 0; k < obs_q.size(); k++) begin
        if (!obs_q[k].rdy) continue;
        checks++;
        e = exp_q.size() ? exp_q.pop_front() : '{g: 3'bxxx, idx: 2'bxx, last: 1'bx};
        if ({obs_q[k].g, obs_q[k].idx, obs_q[k].last} !== {e.g, e.idx, e.last}) begin
          errors++;
          $display("FAIL rnd_group x=%h got g=%b idx=%0d required g=%b idx=%0d",
                   xv, obs_q[k].g, obs_q[k].idx, e.g, e.idx);
        end
        sum += booth_weight(obs_q[k].g) * (1 << (2 * obs_q[k].idx));
      end
      checks++;
      if (exp_q.size() != 0 || sum != int'($signed(xv)) || done_cyc < 5 || idle_viol != 0) begin
        errors++;
        $display("FAIL rnd_sum x=%h sum=%0d missing=%0d done_cyc=%0d required sum=%0d",
                 xv, sum, exp_q.size(), done_cyc, int'($signed(xv)));
      end
      exp_q.delete();
      $display("op random n=%0d x=%h sum=%0d done_cyc=%0d", n, xv, sum, done_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
